// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state codes and shared constants for mem_arbiter2
package mem_arb_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP = 2'd2;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts stalled GRANT cycles and strobes tmo at the limit
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic done,
    output logic tmo
);
    logic [15:0] count;
    always_ff @(posedge clk)
        if (rst || !active) count <= '0;
        else if (!done) count <= count + 16'd1;
    assign tmo = active && count == 16'(TIMEOUT_CYCLES);
endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: two-master arbiter for the native memory bus; `define MEM_ARB_TIMEOUT_EN adds the watchdog
module mem_arbiter2 #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        err
);
    import mem_arb_pkg::*;
    logic [1:0] state;
    logic owner, last, granted, sel1, own_valid, pick, tmo, fire_tmo, ready_o;
    logic [31:0] rdata_o;
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mem_arbiter2: TIMEOUT_CYCLES must be 1..65535");
    end
    assign granted = state == ST_GRANT;
    assign sel1 = owner == M1;
    assign own_valid = sel1 ? m1_valid : m0_valid;
    // tie goes to m0 under fixed priority, otherwise to whoever was not granted last
    assign pick = (m0_valid && m1_valid) ? (FIXED_PRIO ? M0 : ~last) : (m1_valid ? M1 : M0);
`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk(clk),
        .rst(rst),
        .active(granted),
        .done(s_ready),
        .tmo(tmo)
    );
    always_ff @(posedge clk)
        if (rst) err <= 1'b0;
        else if (fire_tmo) err <= 1'b1;
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif
    assign fire_tmo = granted && own_valid && tmo && !s_ready;
    assign ready_o = granted && own_valid && !rst && (s_ready || tmo);
    assign rdata_o = !granted ? '0 : (fire_tmo ? TIMEOUT_RDATA : s_rdata);
    assign m0_ready = ready_o && !sel1;
    assign m1_ready = ready_o && sel1;
    assign m0_rdata = sel1 ? '0 : rdata_o;
    assign m1_rdata = sel1 ? rdata_o : '0;
    assign s_valid = granted && own_valid && !fire_tmo;
    assign s_instr = granted && (sel1 ? m1_instr : m0_instr);
    assign s_addr = !granted ? '0 : (sel1 ? m1_addr : m0_addr);
    assign s_wdata = !granted ? '0 : (sel1 ? m1_wdata : m0_wdata);
    assign s_wstrb = !granted ? '0 : (sel1 ? m1_wstrb : m0_wstrb);
    assign grant = !granted ? 2'b00 : (sel1 ? 2'b10 : 2'b01);
    always_ff @(posedge clk)
        if (rst) begin
            state <= ST_IDLE;
            owner <= M0;
            last <= M1;
        end else if (!granted) begin
            state <= (m0_valid || m1_valid) ? ST_GRANT : ST_IDLE;
            if (m0_valid || m1_valid) begin
                owner <= pick;
                last <= pick;
            end
        end else if (!own_valid || s_ready || tmo) begin
            state <= ST_GAP;
        end
endmodule

// File: tb/tb_mem_arbiter2.sv
// tb_mem_arbiter2: round-robin and fixed-priority instances against an owner-level reference model
module tb_mem_arbiter2;
    localparam int TMO = 8;
    logic clk = 1'b0;
    logic rst;
    logic [1:0] mv, mi;
    logic [31:0] ma [2];
    logic [31:0] mw [2];
    logic [3:0] ms [2];
    logic s_ready;
    logic [31:0] s_rdata;
    logic [1:0] rdy [2];
    logic [31:0] rd [2][2];
    logic sv [2];
    logic si [2];
    logic [31:0] sa [2];
    logic [31:0] sw [2];
    logic [3:0] ss [2];
    logic [1:0] gr [2];
    logic er [2];
    int own [2];
    int last [2];
    int k [2];
    bit err_m [2];
    bit pend [2];
    int n_chk = 0, n_fail = 0, cyc = 0;
    bit did_rst = 0;
    logic [1:0] exp_rdy0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        mem_arbiter2 #(.FIXED_PRIO(d), .TIMEOUT_CYCLES(TMO)) u_dut (
            .clk(clk), .rst(rst),
            .m0_valid(mv[0]), .m0_instr(mi[0]), .m0_addr(ma[0]), .m0_wdata(mw[0]), .m0_wstrb(ms[0]),
            .m0_ready(rdy[d][0]), .m0_rdata(rd[d][0]),
            .m1_valid(mv[1]), .m1_instr(mi[1]), .m1_addr(ma[1]), .m1_wdata(mw[1]), .m1_wstrb(ms[1]),
            .m1_ready(rdy[d][1]), .m1_rdata(rd[d][1]),
            .s_valid(sv[d]), .s_instr(si[d]), .s_addr(sa[d]), .s_wdata(sw[d]), .s_wstrb(ss[d]),
            .s_ready(s_ready), .s_rdata(s_rdata), .grant(gr[d]), .err(er[d])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // d is both the instance index and its FIXED_PRIO setting
    task automatic step(input int d);
        int o, w;
        bit ov, t, ft;
        logic [1:0] e_rdy;
        logic [31:0] e_rd [2];
        o = own[d];
        ov = o >= 0 && mv[o];
        t = 0;
`ifdef MEM_ARB_TIMEOUT_EN
        t = o >= 0 && k[d] == TMO;
`endif
        ft = ov && t && !s_ready;
        e_rdy = (ov && !rst && (s_ready || t)) ? (o == 1 ? 2'b10 : 2'b01) : 2'b00;
        for (int i = 0; i < 2; i++) e_rd[i] = (o == i) ? (ft ? 32'hFFFF_FFFF : s_rdata) : 32'h0;
        if (d == 0) exp_rdy0 = e_rdy;
        chk($sformatf("u%0d.grant", d), 64'(gr[d]), 64'(o < 0 ? 2'b00 : (o == 1 ? 2'b10 : 2'b01)));
        chk($sformatf("u%0d.s_valid", d), 64'(sv[d]), 64'(ov && !ft));
        chk($sformatf("u%0d.s_instr", d), 64'(si[d]), 64'(o >= 0 && mi[o]));
        chk($sformatf("u%0d.s_addr", d), 64'(sa[d]), 64'(o < 0 ? 32'h0 : ma[o]));
        chk($sformatf("u%0d.s_wdata", d), 64'(sw[d]), 64'(o < 0 ? 32'h0 : mw[o]));
        chk($sformatf("u%0d.s_wstrb", d), 64'(ss[d]), 64'(o < 0 ? 4'h0 : ms[o]));
        chk($sformatf("u%0d.ready", d), 64'(rdy[d]), 64'(e_rdy));
        chk($sformatf("u%0d.m0_rdata", d), 64'(rd[d][0]), 64'(e_rd[0]));
        chk($sformatf("u%0d.m1_rdata", d), 64'(rd[d][1]), 64'(e_rd[1]));
        chk($sformatf("u%0d.err", d), 64'(er[d]), 64'(err_m[d]));
        if (rst) begin
            own[d] = -1; last[d] = 1; k[d] = 0; err_m[d] = 0;
        end else if (o < 0) begin
            if (mv != 2'b00) begin
                w = (mv == 2'b11) ? (d == 1 ? 0 : 1 - last[d]) : (mv[1] ? 1 : 0);
                own[d] = w; last[d] = w; k[d] = 0;
            end
        end else if (!mv[o] || s_ready || t) begin
            own[d] = -1;
            if (ft) err_m[d] = 1;
        end else begin
            k[d]++;
        end
    endtask

    initial begin
        rst = 1'b1; mv = '0; mi = '0; s_ready = 1'b0; s_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            ma[i] = '0; mw[i] = '0; ms[i] = '0; pend[i] = 0;
            own[i] = -1; last[i] = 1; k[i] = 0; err_m[i] = 0;
        end
        @(posedge clk); #1;
        for (cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    mv[i] = 1'b0;
                    if (cyc == 1 || $urandom_range(0, 2) == 0) begin
                        pend[i] = 1; mv[i] = 1'b1; mi[i] = 1'($urandom_range(0, 1));
                        ma[i] = $urandom; mw[i] = $urandom;
                        ms[i] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    end
                end else if ($urandom_range(0, 80) == 0) begin
                    pend[i] = 0; mv[i] = 1'b0;
                end
            end
            s_ready = $urandom_range(0, 2) == 0;
            s_rdata = $urandom;
            rst = (cyc < 2) || (cyc >= 1500 && !did_rst && own[0] >= 0 && k[0] == 1);
            if (cyc >= 1500 && rst) did_rst = 1;
            #1;
            step(0);
            step(1);
            for (int i = 0; i < 2; i++) if (exp_rdy0[i]) pend[i] = 0;
            @(posedge clk); #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
